// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: in-order buffer between ROB retire and the branch
// predictor. Accepts up to N resolved branches per cycle. Holes between valid
// slots are squeezed out before the branches are written. Drains the oldest
// entries to W predictor write ports. Also sequences a full table-clear walk.
// Optional build macro: BPQ_PERF_CNT_EN adds the perf_enq/perf_drop
// saturating counters.
module bp_update_scheduler #(
  parameter int N           = 2,
  parameter int W           = 1,
  parameter int DEPTH       = 8,
  parameter int CLR_ENTRIES = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0]                   in_valid,
  input  logic [N*32-1:0]                in_pc,
  input  logic [N-1:0]                   in_taken,
  input  logic [N*32-1:0]                in_target,
  output logic                           in_ready,
  input  logic                           upd_stall,
  output logic [W-1:0]                   upd_valid,
  output logic [W*32-1:0]                upd_pc,
  output logic [W-1:0]                   upd_taken,
  output logic [W*32-1:0]                upd_target,
  input  logic                           clear_req,
  output logic                           clr_valid,
  output logic [$clog2(CLR_ENTRIES)-1:0] clr_idx,
  output logic                           clr_done,
`ifdef BPQ_PERF_CNT_EN
  output logic [31:0]                    perf_enq,
  output logic [31:0]                    perf_drop,
`endif
  output logic                           drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(CLR_ENTRIES);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CLR_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [AW-1:0] head, tail;
  logic [IW-1:0] clr_idx_q;
  entry_t        mem [DEPTH];

  logic [CW-1:0] n_valid, n_enq, n_deq;
  logic [AW-1:0] wr_off [N];
  logic          take_clear, do_enq, deq_active;

  // Slot compaction offsets, enqueue/dequeue amounts and next occupancy.
  // NOTE: every always_comb output gets a default before any branch, so no latches.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < N; i++) begin
      wr_off[i] = n_valid[AW-1:0];
      n_valid   = n_valid + CW'(in_valid[i]);
    end
    take_clear = (state != CLEAR) && clear_req;
    in_ready   = (state != CLEAR) && (count <= READY_MAX);
    do_enq     = in_ready && !take_clear;
    n_enq      = do_enq ? n_valid : '0;
    deq_active = (state == RUN) && !upd_stall;
    n_deq      = '0;
    if (deq_active) n_deq = (count < CW'(W)) ? count : CW'(W);
    count_next = count + n_enq - n_deq;
    drop       = (|in_valid) && !in_ready && !take_clear;
  end

  // Next-state logic: a clear request wins, CLEAR ends on the final index.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx_q == IDX_LAST) state_next = IDLE;
      default: begin
        if (clear_req)             state_next = CLEAR;
        else if (count_next == '0) state_next = IDLE;
        else                       state_next = RUN;
      end
    endcase
  end

  // State, pointers, occupancy and clear-walk index.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      clr_idx_q <= '0;
    end else begin
      state <= state_next;
      if (take_clear) begin
        count     <= '0;
        head      <= '0;
        tail      <= '0;
        clr_idx_q <= '0;
      end else if (state == CLEAR) begin
        clr_idx_q <= (clr_idx_q == IDX_LAST) ? '0 : clr_idx_q + 1'b1;
      end else begin
        count <= count_next;
        head  <= head + n_deq[AW-1:0];
        tail  <= tail + n_enq[AW-1:0];
      end
    end
  end

  // Entry storage: valid slots land at consecutive entries starting at tail.
  // NOTE: the storage array is not reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (do_enq && in_valid[i]) begin
        mem[tail + wr_off[i]] <= '{pc:     in_pc[i*32 +: 32],
                                   taken:  in_taken[i],
                                   target: in_target[i*32 +: 32]};
      end
    end
  end

  // Update ports show the oldest entries. Port j reads head+j.
  always_comb begin
    upd_valid  = '0;
    upd_pc     = '0;
    upd_taken  = '0;
    upd_target = '0;
    for (int j = 0; j < W; j++) begin
      upd_valid[j]           = deq_active && (CW'(j) < count);
      upd_pc[j*32 +: 32]     = mem[head + AW'(j)].pc;
      upd_taken[j]           = mem[head + AW'(j)].taken;
      upd_target[j*32 +: 32] = mem[head + AW'(j)].target;
    end
  end

  // Clear-walk outputs.
  always_comb begin
    clr_valid = (state == CLEAR);
    clr_idx   = clr_idx_q;
    clr_done  = (state == CLEAR) && (clr_idx_q == IDX_LAST);
  end

`ifdef BPQ_PERF_CNT_EN
  logic [32:0] enq_sum;

  // Saturating sum of the entries enqueued so far.
  always_comb enq_sum = {1'b0, perf_enq} + 33'(n_enq);

  // Performance counters. Only reset clears them; a table clear leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_enq  <= '0;
      perf_drop <= '0;
    end else begin
      perf_enq <= enq_sum[32] ? '1 : enq_sum[31:0];
      if (drop && (perf_drop != '1)) perf_drop <= perf_drop + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Testbench for bp_update_scheduler. It runs directed scenarios and then
// random traffic. A queue-based reference model supplies every expected
// output.
module tb_bp_update_scheduler;

  localparam int N           = 2;
  localparam int W           = 1;
  localparam int DEPTH       = 8;
  localparam int CLR_ENTRIES = 32;
  localparam int IW          = $clog2(CLR_ENTRIES);

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      in_valid;
  logic [N*32-1:0]   in_pc;
  logic [N-1:0]      in_taken;
  logic [N*32-1:0]   in_target;
  logic              in_ready;
  logic              upd_stall;
  logic [W-1:0]      upd_valid;
  logic [W*32-1:0]   upd_pc;
  logic [W-1:0]      upd_taken;
  logic [W*32-1:0]   upd_target;
  logic              clear_req;
  logic              clr_valid;
  logic [IW-1:0]     clr_idx;
  logic              clr_done;
  logic              drop;
`ifdef BPQ_PERF_CNT_EN
  logic [31:0]       perf_enq;
  logic [31:0]       perf_drop;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  bit   clearing;
  int   walk;
  int   m_enq;
  int   m_drop;

  bp_update_scheduler #(.N(N), .W(W), .DEPTH(DEPTH), .CLR_ENTRIES(CLR_ENTRIES)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_taken   (in_taken),
    .in_target  (in_target),
    .in_ready   (in_ready),
    .upd_stall  (upd_stall),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .clear_req  (clear_req),
    .clr_valid  (clr_valid),
    .clr_idx    (clr_idx),
    .clr_done   (clr_done),
`ifdef BPQ_PERF_CNT_EN
    .perf_enq   (perf_enq),
    .perf_drop  (perf_drop),
`endif
    .drop       (drop)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random slot data with the given valid mask and control inputs.
  task automatic set_in(input logic [N-1:0] v, input logic stall, input logic clr);
    in_valid  = v;
    upd_stall = stall;
    clear_req = clr;
    for (int i = 0; i < N; i++) begin
      in_pc[i*32 +: 32]     = {$urandom} & 32'hffff_fffc;
      in_taken[i]           = 1'($urandom);
      in_target[i*32 +: 32] = $urandom;
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model over the edge.
  task automatic cycle();
    bit exp_ready, exp_drop, exp_v;
    int pushed;
    #1;
    exp_ready = !clearing && (q.size() <= DEPTH - N);
    exp_drop  = (|in_valid) && !exp_ready && !(clear_req && !clearing);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("drop", 64'(drop), 64'(exp_drop));
    check("clr_valid", 64'(clr_valid), 64'(clearing));
    check("clr_done", 64'(clr_done), 64'(clearing && walk == CLR_ENTRIES - 1));
    if (clearing) check("clr_idx", 64'(clr_idx), 64'(walk));
    for (int j = 0; j < W; j++) begin
      exp_v = !clearing && !upd_stall && (j < q.size());
      check("upd_valid", 64'(upd_valid[j]), 64'(exp_v));
      if (exp_v) begin
        check("upd_pc", 64'(upd_pc[j*32 +: 32]), 64'(q[j].pc));
        check("upd_taken", 64'(upd_taken[j]), 64'(q[j].taken));
        check("upd_target", 64'(upd_target[j*32 +: 32]), 64'(q[j].tgt));
      end
    end
`ifdef BPQ_PERF_CNT_EN
    check("perf_enq", 64'(perf_enq), 64'(m_enq));
    check("perf_drop", 64'(perf_drop), 64'(m_drop));
`endif
    pushed = 0;
    if (reset) begin
      q.delete();
      clearing = 0;
      walk     = 0;
      m_enq    = 0;
      m_drop   = 0;
    end else begin
      if (exp_drop) m_drop++;
      if (clearing) begin
        walk++;
        if (walk == CLR_ENTRIES) clearing = 0;
      end else if (clear_req) begin
        q.delete();
        clearing = 1;
        walk     = 0;
      end else begin
        if (!upd_stall) begin
          for (int j = 0; j < W; j++) if (q.size() > 0) void'(q.pop_front());
        end
        if (exp_ready) begin
          for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
              q.push_back('{pc: in_pc[i*32 +: 32], taken: in_taken[i], tgt: in_target[i*32 +: 32]});
              pushed++;
            end
          end
        end
      end
      m_enq += pushed;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in('0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    q.delete();
    clearing = 0;
    walk     = 0;
    m_enq    = 0;
    m_drop   = 0;
    reset    = 1'b0;

    // Reset state: nothing valid, ready, clear index at 0.
    check("reset_clr_idx", 64'(clr_idx), 64'd0);
    check("reset_upd_valid", 64'(upd_valid), 64'd0);
    cycle();

    // Two valid slots; oldest drains first, one per cycle.
    set_in(2'b11, 1'b0, 1'b0);
    in_pc     = {32'h104, 32'h100};
    in_taken  = 2'b01;
    in_target = {32'h0, 32'h200};
    cycle();
    set_in('0, 1'b0, 1'b0);
    check("t1_first_pc", 64'(upd_pc[31:0]), 64'h100);
    repeat (3) cycle();

    // Slot 0 empty: a single entry is stored.
    set_in(2'b10, 1'b0, 1'b0);
    in_pc[63:32] = 32'h40;
    cycle();
    set_in('0, 1'b0, 1'b0);
    check("t2_pc", 64'(upd_pc[31:0]), 64'h40);
    repeat (2) cycle();

    // Fill to DEPTH-N+1 under stall, then overflow and drain across the pointer wrap.
    for (int k = 0; k < 3; k++) begin
      set_in(2'b11, 1'b1, 1'b0);
      cycle();
    end
    set_in(2'b01, 1'b1, 1'b0);
    cycle();
    set_in(2'b11, 1'b1, 1'b0);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    check("t3_drop", 64'(drop), 64'd1);
    cycle();
`ifdef BPQ_PERF_CNT_EN
    check("t3_perf_drop", 64'(perf_drop), 64'd1);
`endif
    set_in('0, 1'b0, 1'b0);
    repeat (8) cycle();

    // Count 3, then enqueue 2 while dequeuing 1.
    set_in(2'b11, 1'b1, 1'b0);
    cycle();
    set_in(2'b01, 1'b1, 1'b0);
    cycle();
    set_in(2'b11, 1'b0, 1'b0);
    cycle();
    set_in('0, 1'b1, 1'b0);
    cycle();
    // Four entries remain: two more groups of two would exceed DEPTH-N.
    set_in(2'b11, 1'b1, 1'b0);
    cycle();
    check("t4_ready_at_6", 64'(in_ready), 64'd1);
    set_in('0, 1'b1, 1'b0);
    cycle();

    // Drain to 5, then a clear request with traffic presented during the walk.
    set_in('0, 1'b0, 1'b0);
    cycle();
    set_in(2'b11, 1'b1, 1'b1);
    cycle();
    for (int k = 0; k < CLR_ENTRIES; k++) begin
      set_in(2'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end
    set_in('0, 1'b0, 1'b0);
    check("t5_after_ready", 64'(in_ready), 64'd1);
    check("t5_after_clr", 64'(clr_valid), 64'd0);
    cycle();

    // Reset in the middle of a walk.
    set_in(2'b01, 1'b0, 1'b0);
    cycle();
    set_in('0, 1'b0, 1'b1);
    cycle();
    set_in('0, 1'b0, 1'b0);
    while (walk < 10) cycle();
    reset = 1'b1;
    check("t6_idx10", 64'(clr_idx), 64'd10);
    cycle();
    reset = 1'b0;
    check("t6_clr_valid", 64'(clr_valid), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd1);
    cycle();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      set_in(2'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 2));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
